// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a FIFO of pending characters feeding a
// start / data / optional parity / stop serialiser with a registered TX pin.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                        CLK_100MHz,
    input  logic                        RST_N,
    input  logic                        LOAD,
    input  logic [15:0]                 IN,
    output logic                        TX,
    output logic                        TX_BUSY,
    output logic                        FULL,
    output logic                        EMPTY,
    output logic [$clog2(FIFO_DEPTH):0] COUNT,
    output logic                        OVERRUN
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 full_q, empty_q, overrun_q;

    state_t               state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] frame_q, frame_d;
    logic                 tx_q, busy_q;

    logic                 push_c, pop_c, tx_c, parity_c;
    logic                 bit_done_c, stop_done_c;
    logic                 unused_in_c;

    assign unused_in_c = ^IN[15:DATA_BITS];

    // A push is only accepted against the registered FULL flag
    assign push_c = LOAD && !full_q;

    assign bit_done_c  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign stop_done_c = (baud_q == BAUD_W'(STOP_BITS * CLKS_PER_BIT - 1));
    assign parity_c    = (^frame_q) ^ (PARITY == 2);

    always_ff @(posedge CLK_100MHz) begin
        if (push_c) begin
            mem[wr_ptr_q] <= IN[DATA_BITS-1:0];
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and flags; flags are stored so they come straight from flops
    always_ff @(posedge CLK_100MHz or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(FIFO_DEPTH));
            empty_q <= (count_d == '0);
            if (LOAD && full_q) begin
                overrun_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_100MHz or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            frame_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            tx_q    <= tx_c;
            busy_q  <= (state_q != S_IDLE) || !empty_q;
        end
    end

    // Serialiser: the line level is chosen from the current state and lands on the pin one cycle later
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        pop_c   = 1'b0;
        tx_c    = 1'b1;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!empty_q) begin
                    pop_c   = 1'b1;
                    frame_d = mem[rd_ptr_q];
                    state_d = S_START;
                end
            end
            S_START: begin
                tx_c = 1'b0;
                if (bit_done_c) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                tx_c = frame_q[bit_q];
                if (bit_done_c) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_PARITY: begin
                tx_c = parity_c;
                if (bit_done_c) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                tx_c = 1'b1;
                // Popping on the last stop cycle chains frames with no idle gap
                if (stop_done_c) begin
                    baud_d = '0;
                    if (!empty_q) begin
                        pop_c   = 1'b1;
                        frame_d = mem[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign TX      = tx_q;
    assign TX_BUSY = busy_q;
    assign FULL    = full_q;
    assign EMPTY   = empty_q;
    assign COUNT   = count_q;
    assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations driven from one clock, line
// waveforms compared against frames built from the character data.
module tb_uart_tx_fifo;

    localparam int unsigned CPB = 4;

    typedef logic bitq_t[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load [3];
    logic [15:0] din  [3];
    logic        tx   [3];
    logic        busy [3];
    logic        full [3];
    logic        empty[3];
    logic        ovr  [3];
    logic [4:0]  cnt_a;
    logic [2:0]  cnt_b, cnt_c;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    // a: 8N1 depth 16, b: 8E2 depth 4, c: 8O1 depth 4
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_a (
        .CLK_100MHz(clk), .RST_N(rst_n), .LOAD(load[0]), .IN(din[0]), .TX(tx[0]), .TX_BUSY(busy[0]),
        .FULL(full[0]), .EMPTY(empty[0]), .COUNT(cnt_a), .OVERRUN(ovr[0]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
        .CLK_100MHz(clk), .RST_N(rst_n), .LOAD(load[1]), .IN(din[1]), .TX(tx[1]), .TX_BUSY(busy[1]),
        .FULL(full[1]), .EMPTY(empty[1]), .COUNT(cnt_b), .OVERRUN(ovr[1]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
        .CLK_100MHz(clk), .RST_N(rst_n), .LOAD(load[2]), .IN(din[2]), .TX(tx[2]), .TX_BUSY(busy[2]),
        .FULL(full[2]), .EMPTY(empty[2]), .COUNT(cnt_c), .OVERRUN(ovr[2]));

    function automatic int count_of(input int idx);
        case (idx)
            0:       return int'(cnt_a);
            1:       return int'(cnt_b);
            default: return int'(cnt_c);
        endcase
    endfunction

    // Expected line levels of one frame, one entry per clock cycle
    function automatic void add_frame(input logic [7:0] d, input int par, input int sb, inout bitq_t w);
        bitq_t      bits;
        logic [7:0] s;
        int         ones;
        s    = d;
        ones = $countones(d);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            bits.push_back(s[0]);
            s = s >> 1;
        end
        if (par == 1) bits.push_back((ones % 2) == 1);
        if (par == 2) bits.push_back((ones % 2) == 0);
        for (int i = 0; i < sb; i++) bits.push_back(1'b1);
        foreach (bits[b]) begin
            for (int c = 0; c < int'(CPB); c++) w.push_back(bits[b]);
        end
    endfunction

    function automatic int first_diff(input bitq_t g, input bitq_t e);
        if (g.size() != e.size()) return (g.size() < e.size()) ? g.size() : e.size();
        foreach (e[i]) if (g[i] !== e[i]) return i;
        return -1;
    endfunction

    // Samples every TX pin starting now, one sample per falling edge
    task automatic sample_all(input int n, output bitq_t w0, output bitq_t w1, output bitq_t w2);
        w0 = {};
        w1 = {};
        w2 = {};
        for (int i = 0; i < n; i++) begin
            w0.push_back(tx[0]);
            w1.push_back(tx[1]);
            w2.push_back(tx[2]);
            @(negedge clk);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (tx[i] !== 1'b1) begin tests_failed++; $display("FAIL reset_tx[%0d]: got %b expected 1", i, tx[i]); end
            tests_run++; if (busy[i] !== 1'b0) begin tests_failed++; $display("FAIL reset_busy[%0d]: got %b expected 0", i, busy[i]); end
            tests_run++; if (full[i] !== 1'b0) begin tests_failed++; $display("FAIL reset_full[%0d]: got %b expected 0", i, full[i]); end
            tests_run++; if (empty[i] !== 1'b1) begin tests_failed++; $display("FAIL reset_empty[%0d]: got %b expected 1", i, empty[i]); end
            tests_run++; if (ovr[i] !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun[%0d]: got %b expected 0", i, ovr[i]); end
            tests_run++; if (count_of(i) != 0) begin tests_failed++; $display("FAIL reset_count[%0d]: got %0d expected 0", i, count_of(i)); end
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (tx[i] !== 1'b1 || busy[i] !== 1'b0) begin
                tests_failed++; $display("FAIL idle_after_reset[%0d]: got tx=%b busy=%b expected tx=1 busy=0", i, tx[i], busy[i]);
            end
        end
    endtask

    task automatic test_basic();
        bitq_t w0, w1, w2, e;
        add_frame(8'h55, 0, 1, e);
        load[0] = 1'b1; din[0] = 16'h0A55;
        @(negedge clk);
        load[0] = 1'b0;
        tests_run++; if (cnt_a !== 5'd1) begin tests_failed++; $display("FAIL basic_count_push: got %0d expected 1", cnt_a); end
        @(negedge clk);
        tests_run++; if (cnt_a !== 5'd0 || tx[0] !== 1'b1 || busy[0] !== 1'b1) begin
            tests_failed++; $display("FAIL basic_after_pop: got count=%0d tx=%b busy=%b expected 0 1 1", cnt_a, tx[0], busy[0]);
        end
        @(negedge clk);
        sample_all(40, w0, w1, w2);
        tests_run++; if (first_diff(w0, e) >= 0) begin
            tests_failed++; $display("FAIL basic_wave: differs at cycle %0d got %b expected %b", first_diff(w0, e), w0[first_diff(w0, e)], e[first_diff(w0, e)]);
        end
        tests_run++; if (busy[0] !== 1'b0 || tx[0] !== 1'b1 || empty[0] !== 1'b1) begin
            tests_failed++; $display("FAIL basic_end: got busy=%b tx=%b empty=%b expected 0 1 1", busy[0], tx[0], empty[0]);
        end
    endtask

    task automatic test_parity();
        bitq_t w0, w1, w2, eb, ec;
        logic [7:0] d;
        for (int k = 0; k < 3; k++) begin
            d  = (k == 0) ? 8'h07 : 8'($urandom);
            eb = {};
            ec = {};
            add_frame(d, 1, 2, eb);
            add_frame(d, 2, 1, ec);
            for (int i = 0; i < int'(CPB); i++) ec.push_back(1'b1);
            load[1] = 1'b1; din[1] = {8'($urandom), d};
            load[2] = 1'b1; din[2] = {8'($urandom), d};
            @(negedge clk);
            load[1] = 1'b0;
            load[2] = 1'b0;
            @(negedge clk);
            @(negedge clk);
            sample_all(48, w0, w1, w2);
            if (k == 0) begin
                tests_run++; if (w1[37] !== 1'b1) begin tests_failed++; $display("FAIL even_parity_07: got %b expected 1", w1[37]); end
                tests_run++; if (w2[37] !== 1'b0) begin tests_failed++; $display("FAIL odd_parity_07: got %b expected 0", w2[37]); end
            end
            tests_run++; if (first_diff(w1, eb) >= 0) begin
                tests_failed++; $display("FAIL wave_8e2 data=%h: differs at cycle %0d got %b expected %b", d, first_diff(w1, eb), w1[first_diff(w1, eb)], eb[first_diff(w1, eb)]);
            end
            tests_run++; if (first_diff(w2, ec) >= 0) begin
                tests_failed++; $display("FAIL wave_8o1 data=%h: differs at cycle %0d got %b expected %b", d, first_diff(w2, ec), w2[first_diff(w2, ec)], ec[first_diff(w2, ec)]);
            end
            tests_run++; if (busy[1] !== 1'b0 || busy[2] !== 1'b0) begin
                tests_failed++; $display("FAIL parity_busy_end: got %b %b expected 0 0", busy[1], busy[2]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bitq_t w0, w1, w2, e;
        add_frame(8'h01, 0, 1, e);
        add_frame(8'h02, 0, 1, e);
        add_frame(8'h03, 0, 1, e);
        load[0] = 1'b1; din[0] = 16'h0001;
        @(negedge clk);
        tests_run++; if (cnt_a !== 5'd1) begin tests_failed++; $display("FAIL b2b_count_1: got %0d expected 1", cnt_a); end
        din[0] = 16'h0002;
        @(negedge clk);
        tests_run++; if (cnt_a !== 5'd1) begin tests_failed++; $display("FAIL b2b_count_push_pop: got %0d expected 1", cnt_a); end
        din[0] = 16'h0003;
        @(negedge clk);
        load[0] = 1'b0;
        tests_run++; if (cnt_a !== 5'd2 || busy[0] !== 1'b1) begin
            tests_failed++; $display("FAIL b2b_count_2: got count=%0d busy=%b expected 2 1", cnt_a, busy[0]);
        end
        sample_all(120, w0, w1, w2);
        tests_run++; if (first_diff(w0, e) >= 0) begin
            tests_failed++; $display("FAIL b2b_wave: differs at cycle %0d got %b expected %b", first_diff(w0, e), w0[first_diff(w0, e)], e[first_diff(w0, e)]);
        end
        tests_run++; if (busy[0] !== 1'b0 || cnt_a !== 5'd0) begin
            tests_failed++; $display("FAIL b2b_end: got busy=%b count=%0d expected 0 0", busy[0], cnt_a);
        end
    endtask

    task automatic test_random_burst();
        bitq_t       w0, w1, w2, e;
        logic [15:0] dat[$];
        int          n;
        n = int'($urandom_range(4, 7));
        for (int i = 0; i < n; i++) dat.push_back(16'($urandom));
        e.push_back(1'b1);
        e.push_back(1'b1);
        for (int i = 0; i < n; i++) add_frame(dat[i][7:0], 0, 1, e);
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    load[0] = 1'b1; din[0] = dat[i];
                    @(negedge clk);
                end
                load[0] = 1'b0;
            end
            begin
                @(negedge clk);
                sample_all(n * 40 + 2, w0, w1, w2);
            end
        join
        tests_run++; if (first_diff(w0, e) >= 0) begin
            tests_failed++; $display("FAIL random_burst_wave n=%0d: differs at cycle %0d got %b expected %b", n, first_diff(w0, e), w0[first_diff(w0, e)], e[first_diff(w0, e)]);
        end
        tests_run++; if (busy[0] !== 1'b0 || empty[0] !== 1'b1) begin
            tests_failed++; $display("FAIL random_burst_end: got busy=%b empty=%b expected 0 1", busy[0], empty[0]);
        end
    endtask

    task automatic test_overrun();
        bitq_t      w0, w1, w2, e;
        logic [7:0] dat[$];
        for (int i = 0; i < 7; i++) dat.push_back(8'($urandom));
        for (int i = 0; i < 5; i++) add_frame(dat[i], 2, 1, e);
        fork
            begin
                load[2] = 1'b1; din[2] = {8'h00, dat[0]};
                @(negedge clk);
                load[2] = 1'b0;
                repeat (4) @(negedge clk);
                for (int k = 0; k < 6; k++) begin
                    if (k == 4) begin
                        tests_run++; if (cnt_c !== 3'd4 || full[2] !== 1'b1 || ovr[2] !== 1'b0) begin
                            tests_failed++; $display("FAIL overrun_full: got count=%0d full=%b ovr=%b expected 4 1 0", cnt_c, full[2], ovr[2]);
                        end
                    end
                    load[2] = 1'b1; din[2] = {8'h00, dat[k + 1]};
                    @(negedge clk);
                end
                load[2] = 1'b0;
                tests_run++; if (cnt_c !== 3'd4 || ovr[2] !== 1'b1) begin
                    tests_failed++; $display("FAIL overrun_drop: got count=%0d ovr=%b expected 4 1", cnt_c, ovr[2]);
                end
            end
            begin
                repeat (3) @(negedge clk);
                sample_all(220, w0, w1, w2);
            end
        join
        tests_run++; if (first_diff(w2, e) >= 0) begin
            tests_failed++; $display("FAIL overrun_wave: differs at cycle %0d got %b expected %b", first_diff(w2, e), w2[first_diff(w2, e)], e[first_diff(w2, e)]);
        end
        tests_run++; if (busy[2] !== 1'b0 || empty[2] !== 1'b1 || ovr[2] !== 1'b1) begin
            tests_failed++; $display("FAIL overrun_end: got busy=%b empty=%b ovr=%b expected 0 1 1", busy[2], empty[2], ovr[2]);
        end
    endtask

    task automatic test_push_pop();
        bitq_t      w0, w1, w2, e;
        logic [7:0] dat[$];
        for (int i = 0; i < 7; i++) dat.push_back(8'($urandom));
        for (int i = 0; i < 6; i++) add_frame(dat[i], 2, 1, e);
        fork
            begin
                load[2] = 1'b1; din[2] = {8'h00, dat[0]};
                @(negedge clk);
                din[2] = {8'h00, dat[1]};
                @(negedge clk);
                din[2] = {8'h00, dat[2]};
                @(negedge clk);
                load[2] = 1'b0;
                tests_run++; if (cnt_c !== 3'd2) begin tests_failed++; $display("FAIL pp_count_before: got %0d expected 2", cnt_c); end
                repeat (42) @(negedge clk);
                load[2] = 1'b1; din[2] = {8'h00, dat[3]};
                @(negedge clk);
                tests_run++; if (cnt_c !== 3'd2) begin tests_failed++; $display("FAIL pp_simultaneous: got %0d expected 2", cnt_c); end
                din[2] = {8'h00, dat[4]};
                @(negedge clk);
                din[2] = {8'h00, dat[5]};
                @(negedge clk);
                load[2] = 1'b0;
                tests_run++; if (cnt_c !== 3'd4 || full[2] !== 1'b1) begin
                    tests_failed++; $display("FAIL pp_full: got count=%0d full=%b expected 4 1", cnt_c, full[2]);
                end
                repeat (41) @(negedge clk);
                tests_run++; if (full[2] !== 1'b1 || ovr[2] !== 1'b0) begin
                    tests_failed++; $display("FAIL pp_pre_reject: got full=%b ovr=%b expected 1 0", full[2], ovr[2]);
                end
                load[2] = 1'b1; din[2] = {8'h00, dat[6]};
                @(negedge clk);
                load[2] = 1'b0;
                tests_run++; if (cnt_c !== 3'd3 || full[2] !== 1'b0 || ovr[2] !== 1'b1) begin
                    tests_failed++; $display("FAIL pp_reject_full_pop: got count=%0d full=%b ovr=%b expected 3 0 1", cnt_c, full[2], ovr[2]);
                end
            end
            begin
                repeat (3) @(negedge clk);
                sample_all(264, w0, w1, w2);
            end
        join
        tests_run++; if (first_diff(w2, e) >= 0) begin
            tests_failed++; $display("FAIL pp_wave: differs at cycle %0d got %b expected %b", first_diff(w2, e), w2[first_diff(w2, e)], e[first_diff(w2, e)]);
        end
        tests_run++; if (busy[2] !== 1'b0 || cnt_c !== 3'd0) begin
            tests_failed++; $display("FAIL pp_end: got busy=%b count=%0d expected 0 0", busy[2], cnt_c);
        end
    endtask

    task automatic test_reset_mid();
        bitq_t      w0, w1, w2, e;
        logic [7:0] d;
        d = 8'($urandom);
        add_frame(d, 0, 1, e);
        tests_run++; if (ovr[2] !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_overrun: got %b expected 1", ovr[2]); end
        load[0] = 1'b1; din[0] = 16'h00A5;
        @(negedge clk);
        din[0] = 16'h003C;
        @(negedge clk);
        load[0] = 1'b0;
        repeat (18) @(negedge clk);
        tests_run++; if (tx[0] !== 1'b0 || empty[0] !== 1'b0) begin
            tests_failed++; $display("FAIL mid_bit3: got tx=%b empty=%b expected 0 0", tx[0], empty[0]);
        end
        #1 rst_n = 1'b0;
        #1;
        tests_run++; if (tx[0] !== 1'b1) begin tests_failed++; $display("FAIL mid_async_tx: got %b expected 1", tx[0]); end
        tests_run++; if (empty[0] !== 1'b1 || cnt_a !== 5'd0 || busy[0] !== 1'b0) begin
            tests_failed++; $display("FAIL mid_async_fifo: got empty=%b count=%0d busy=%b expected 1 0 0", empty[0], cnt_a, busy[0]);
        end
        tests_run++; if (ovr[2] !== 1'b0) begin tests_failed++; $display("FAIL mid_async_overrun: got %b expected 0", ovr[2]); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load[0] = 1'b1; din[0] = {8'h00, d};
        @(negedge clk);
        load[0] = 1'b0;
        @(negedge clk);
        tests_run++; if (tx[0] !== 1'b1) begin tests_failed++; $display("FAIL mid_restart_idle: got %b expected 1", tx[0]); end
        @(negedge clk);
        sample_all(40, w0, w1, w2);
        tests_run++; if (first_diff(w0, e) >= 0) begin
            tests_failed++; $display("FAIL mid_restart_wave: differs at cycle %0d got %b expected %b", first_diff(w0, e), w0[first_diff(w0, e)], e[first_diff(w0, e)]);
        end
        tests_run++; if (busy[0] !== 1'b0) begin tests_failed++; $display("FAIL mid_restart_end: got busy=%b expected 0", busy[0]); end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load[i] = 1'b0;
            din[i]  = 16'h0000;
        end
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_random_burst();
        test_overrun();
        pulse_reset();
        test_push_pop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
